// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: first-word-fall-through FIFO controller around one
// ram_simple_dual instance. The RAM's registered dob is the output register.
// Optional feature: define RAM_FIFO_CTRL_AFULL_EN to build the almost_full
// comparator; otherwise almost_full is tied low.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dia,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob
);

    // RAM holds exactly DEPTH entries; the head register adds one more.
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ZERO_C  = '0;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  out_valid_q;
    logic                  push;
    logic                  pop;
    logic                  rd;

    // in_ready looks only at registered occupancy and flush, never out_ready,
    // so a full FIFO cannot pass a word through in the same cycle.
    assign in_ready = (ram_cnt != DEPTH_C) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;
    // Prefetch into dob whenever the head slot is empty or being consumed.
    // ram_cnt excludes this cycle's push, so rd never hits the write address.
    assign rd       = (ram_cnt != ZERO_C) && (!out_valid_q || out_ready) && !flush;

    assign ram_ena   = push;
    assign ram_wea   = push;
    assign ram_addra = wr_ptr;
    assign ram_dia   = in_data;
    assign ram_enb   = rd;
    assign ram_addrb = rd_ptr;

    assign out_valid = out_valid_q;
    assign out_data  = ram_dob;
    assign level     = ram_cnt + {{ADDR_WIDTH{1'b0}}, out_valid_q};

`ifdef RAM_FIFO_CTRL_AFULL_EN
    localparam logic [ADDR_WIDTH:0] AFULL_C = AFULL_THRESH[ADDR_WIDTH:0];
    assign almost_full = (level >= AFULL_C);
`else
    assign almost_full = 1'b0;
`endif

    // Pointers wrap naturally; flush and reset clear them to the same state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (rd)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // RAM occupancy: simultaneous push and read cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cnt <= '0;
        end else if (flush) begin
            ram_cnt <= '0;
        end else begin
            case ({push, rd})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase
        end
    end

    // Head valid: a read reloads dob, otherwise a pop empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (rd) begin
            out_valid_q <= 1'b1;
        end else if (pop) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a small behavioural RAM and a queue-based
// reference model of the FIFO (RAM backlog queue plus a head slot).
module tb_ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 2**AW;
    localparam int ATH   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;
    logic          almost_full;
    logic          ram_ena, ram_wea, ram_enb;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dia, ram_dob;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic [DW-1:0] m_q[$];
    bit            m_hv;
    logic [DW-1:0] m_hd;

    logic [DW-1:0] mem [DEPTH];

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(ATH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .almost_full(almost_full),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
    );

    always #5 clk = ~clk;

    // simple dual-port RAM with registered read port
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_level();
        return m_q.size() + (m_hv ? 1 : 0);
    endfunction

    // One clock: drive at negedge, check against model, advance model.
    task automatic cycle(input bit iv, input logic [DW-1:0] id, input bit ordy, input bit fl);
        bit m_push, m_rd, m_pop, exp_af;
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
        #1;
        m_push = iv && (m_q.size() < DEPTH) && !fl;
        m_rd   = (m_q.size() > 0) && (!m_hv || ordy) && !fl;
        m_pop  = m_hv && ordy;
`ifdef RAM_FIFO_CTRL_AFULL_EN
        exp_af = (m_level() >= ATH);
`else
        exp_af = 1'b0;
`endif
        chk("in_ready",    32'(in_ready),    32'((m_q.size() < DEPTH) && !fl));
        chk("out_valid",   32'(out_valid),   32'(m_hv));
        chk("level",       32'(level),       32'(m_level()));
        chk("almost_full", 32'(almost_full), 32'(exp_af));
        chk("ram_enb",     32'(ram_enb),     32'(m_rd));
        chk("ram_ena",     32'(ram_ena),     32'(m_push));
        if (m_hv) chk("out_data", 32'(out_data), 32'(m_hd));
        if (fl) begin
            m_q.delete();
            m_hv = 1'b0;
        end else begin
            if (m_rd) begin
                m_hd = m_q.pop_front();
                m_hv = 1'b1;
            end else if (m_pop) begin
                m_hv = 1'b0;
            end
            if (m_push) m_q.push_back(id);
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_hv = 1'b0; m_hd = '0;
        #2;
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_level",     32'(level),       32'd0);
        chk("rst_afull",     32'(almost_full), 32'd0);
        chk("rst_enables",   32'({ram_ena, ram_wea, ram_enb}), 32'd0);
        chk("rst_addrs",     32'({ram_addra, ram_addrb}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // streaming: A0..A3 with out_ready held high
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_level", 32'(level), 32'd0);

        // fill to DEPTH+1 with consumer stalled; 6th word held until a pop
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h15, 1'b0, 1'b0);
        chk("full_level", 32'(level), 32'd5);
        chk("full_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 8'h15, 1'b1, 1'b0);
        cycle(1'b1, 8'h15, 1'b0, 1'b0);

        // full throughput across pointer wrap
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h4F, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // asynchronous reset with 3 entries held
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_level",     32'(level),     32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        m_q.delete(); m_hv = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h70 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            d = 8'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("final_level", 32'(level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
